viterbi_frame_ctrl: RTL and testbench

//  Frame sequencer for the vencoder/vdecoder pair. Latches a parallel message word and

---
 rtl/viterbi_frame_ctrl.sv | 120 ++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer for the vencoder/vdecoder pair: serialises a message word
// MSB-first into the encoder, appends zero tail bits, drains the decoder and
// deserialises the decoded bits back into rx_msg.
//
// Ports:
//   clock      system clock, all logic on the rising edge
//   reset      asynchronous active-low reset
//   start      frame request, sampled only while idle
//   msg        message word, latched when start is accepted
//   busy       high while a frame is running
//   sym_phase  0 = first, 1 = second cycle of a symbol period
//   enc_in     serial bit to the encoder
//   dec_bit    serial decoded bit from the decoder
//   dec_err    decoder error flag
//   done       one-cycle pulse when rx_msg/frame_err are valid
//   rx_msg     recovered message, held until the next accepted start
//   frame_err  OR of dec_err over the capture slots, held like rx_msg
module viterbi_frame_ctrl #(
    parameter int MSG_BITS    = 8,
    parameter int TAIL_BITS   = 2,
    parameter int DEC_LATENCY = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [MSG_BITS-1:0] msg,
    output logic                busy,
    output logic                sym_phase,
    output logic                enc_in,
    input  logic                dec_bit,
    input  logic                dec_err,
    output logic                done,
    output logic [MSG_BITS-1:0] rx_msg,
    output logic                frame_err
);

    localparam int NSYM_ENC = MSG_BITS + TAIL_BITS;
    localparam int NSYM_DEC = DEC_LATENCY + MSG_BITS;
    localparam int NSYM     = (NSYM_ENC > NSYM_DEC) ? NSYM_ENC : NSYM_DEC;
    localparam int CW       = $clog2(NSYM + 1);

    localparam logic [CW-1:0] LAST = CW'(NSYM - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t              state;
    logic [CW-1:0]       sym_cnt;
    logic [MSG_BITS-1:0] msg_sh;
    logic                capture;

    // Capture slots: symbol counts whose decoder output carries message bits.
    assign capture = sym_phase
                  && (int'(sym_cnt) >= DEC_LATENCY)
                  && (int'(sym_cnt) <  DEC_LATENCY + MSG_BITS);

    // msg_sh shifts left once per symbol, so its bit MSG_BITS-2 is always the
    // next message bit; zeros shifted in supply the tail and drain symbols.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            sym_phase <= 1'b0;
            enc_in    <= 1'b0;
            done      <= 1'b0;
            rx_msg    <= '0;
            frame_err <= 1'b0;
            sym_cnt   <= '0;
            msg_sh    <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        msg_sh    <= msg;
                        rx_msg    <= '0;
                        frame_err <= 1'b0;
                        sym_cnt   <= '0;
                        sym_phase <= 1'b0;
                        enc_in    <= msg[MSG_BITS-1];
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        enc_in <= 1'b0;
                    end
                end
                RUN: begin
                    sym_phase <= ~sym_phase;
                    if (capture) begin
                        rx_msg    <= {rx_msg[MSG_BITS-2:0], dec_bit};
                        frame_err <= frame_err | dec_err;
                    end
                    if (sym_phase) begin
                        if (sym_cnt == LAST) begin
                            enc_in    <= 1'b0;
                            busy      <= 1'b0;
                            sym_phase <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end else begin
                            sym_cnt <= sym_cnt + 1'b1;
                            msg_sh  <= msg_sh << 1;
                            enc_in  <= msg_sh[MSG_BITS-2];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: default-parameter instance in 6-symbol
// loopback and a zero-latency instance in direct loopback.
module tb_viterbi_frame_ctrl;

    typedef struct {
        logic [7:0] rx;
        logic       err;
        int         acc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic       start0 = 1'b0, start1 = 1'b0;
    logic [7:0] msg0 = '0, msg1 = '0;
    logic       derr0 = 1'b0, derr1 = 1'b0;
    logic       busy0, phase0, enc0, done0, ferr0, dbit0;
    logic       busy1, phase1, enc1, done1, ferr1, dbit1;
    logic [7:0] rx0, rx1;
    logic [11:0] dly = '0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // 6-symbol (12-cycle) loopback delay for the default instance.
    always @(posedge clock) dly <= {dly[10:0], enc0};
    assign dbit0 = dly[11];
    assign dbit1 = enc1;

    viterbi_frame_ctrl u0 (
        .clock(clock), .reset(reset), .start(start0), .msg(msg0),
        .busy(busy0), .sym_phase(phase0), .enc_in(enc0),
        .dec_bit(dbit0), .dec_err(derr0), .done(done0),
        .rx_msg(rx0), .frame_err(ferr0)
    );

    viterbi_frame_ctrl #(
        .MSG_BITS(8), .TAIL_BITS(2), .DEC_LATENCY(0)
    ) u1 (
        .clock(clock), .reset(reset), .start(start1), .msg(msg1),
        .busy(busy1), .sym_phase(phase1), .enc_in(enc1),
        .dec_bit(dbit1), .dec_err(derr1), .done(done1),
        .rx_msg(rx1), .frame_err(ferr1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Monitors: pop the expected frame result whenever done pulses.
    always @(negedge clock) begin
        exp_t e;
        if (reset && done0 === 1'b1) begin
            chk("done0_expected", 32'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("rx_msg0", 32'(rx0), 32'(e.rx));
                chk("frame_err0", 32'(ferr0), 32'(e.err));
                chk("latency0", 32'(cyc - e.acc), 28);
            end
        end
    end

    always @(negedge clock) begin
        exp_t e;
        if (reset && done1 === 1'b1) begin
            chk("done1_expected", 32'(q1.size() > 0), 1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("rx_msg1", 32'(rx1), 32'(e.rx));
                chk("frame_err1", 32'(ferr1), 32'(e.err));
                chk("latency1", 32'(cyc - e.acc), 20);
            end
        end
    end

    // One frame on instance sel. mask bit j raises dec_err for symbol j.
    // abort_sym >= 0 pulls reset low during that symbol and returns.
    task automatic run_frame(input bit sel, input logic [7:0] m,
                             input logic [15:0] mask, input bit hold,
                             input int abort_sym);
        int   n;
        int   dl;
        int   k;
        exp_t e;
        logic eerr;
        logic ebit;
        n = sel ? 10 : 14;
        dl = sel ? 0 : 6;
        eerr = 1'b0;
        for (int j = dl; j < dl + 8; j++) eerr |= mask[j];
        @(negedge clock);
        if (sel) begin start1 = 1'b1; msg1 = m; end
        else begin start0 = 1'b1; msg0 = m; end
        @(posedge clock);
        for (int c = 0; c <= 2 * n; c++) begin
            @(negedge clock);
            k = c / 2;
            if (c == 0) begin
                e = '{rx: m, err: eerr, acc: cyc};
                if (sel) q1.push_back(e);
                else q0.push_back(e);
                chk("rx_clear", 32'(sel ? rx1 : rx0), 0);
                chk("err_clear", 32'(sel ? ferr1 : ferr0), 0);
            end
            if (c < 2 * n) begin
                ebit = (k < 8) ? m[7-k] : 1'b0;
                chk("enc_in", 32'(sel ? enc1 : enc0), 32'(ebit));
                chk("busy", 32'(sel ? busy1 : busy0), 1);
                chk("sym_phase", 32'(sel ? phase1 : phase0), 32'(c % 2));
            end else begin
                chk("enc_in_end", 32'(sel ? enc1 : enc0), 0);
                chk("busy_end", 32'(sel ? busy1 : busy0), 0);
                chk("phase_end", 32'(sel ? phase1 : phase0), 0);
            end
            if (sel) begin
                msg1 = 8'($urandom);
                start1 = hold;
                derr1 = (c < 2 * n) ? mask[k] : 1'b0;
            end else begin
                msg0 = 8'($urandom);
                start0 = hold;
                derr0 = (c < 2 * n) ? mask[k] : 1'b0;
            end
            if (c == 2 * abort_sym) begin
                #2 reset = 1'b0;
                #1;
                chk("abort_busy", 32'(busy0), 0);
                chk("abort_phase", 32'(phase0), 0);
                chk("abort_enc", 32'(enc0), 0);
                chk("abort_done", 32'(done0), 0);
                chk("abort_rx", 32'(rx0), 0);
                chk("abort_err", 32'(ferr0), 0);
                q0.delete();
                start0 = 1'b0;
                derr0 = 1'b0;
                return;
            end
        end
        @(posedge clock);
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clock);
            chk("idle_busy", 32'(busy0), 0);
            chk("idle_done", 32'(done0), 0);
        end
    endtask

    initial begin
        logic [15:0] mask;
        bit          hold;
        repeat (3) @(negedge clock);
        chk("rst_busy", 32'({busy0, busy1}), 0);
        chk("rst_phase", 32'({phase0, phase1}), 0);
        chk("rst_enc", 32'({enc0, enc1}), 0);
        chk("rst_done", 32'({done0, done1}), 0);
        chk("rst_rx", 32'({rx0, rx1}), 0);
        chk("rst_err", 32'({ferr0, ferr1}), 0);
        reset = 1'b1;
        idle_check(5);

        run_frame(0, 8'h5C, 16'h0000, 0, -1);
        run_frame(0, 8'h5C, 16'h0400, 0, -1);
        run_frame(0, 8'h5C, 16'h0004, 0, -1);
        run_frame(0, 8'h37, 16'h0080, 1, -1);
        run_frame(0, 8'h91, 16'h0000, 0, -1);

        run_frame(0, 8'h66, 16'h0000, 0, 5);
        @(negedge clock);
        reset = 1'b1;
        idle_check(5);
        run_frame(0, 8'hA3, 16'h0000, 0, -1);

        for (int i = 0; i < 20; i++) begin
            mask = 16'($urandom & $urandom & $urandom) & 16'h3FFF;
            if ($urandom_range(0, 2) == 0) mask = '0;
            hold = (i < 19) && ($urandom_range(0, 3) == 0);
            run_frame(0, 8'($urandom), mask, hold, -1);
        end

        run_frame(1, 8'hFF, 16'h0000, 0, -1);
        run_frame(1, 8'h5A, 16'h0200, 0, -1);
        for (int i = 0; i < 10; i++) begin
            mask = 16'($urandom & $urandom) & 16'h03FF;
            run_frame(1, 8'($urandom), mask, 0, -1);
        end

        repeat (40) @(negedge clock);
        chk("pending0", 32'(q0.size()), 0);
        chk("pending1", 32'(q1.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
